// File: rtl/micro_sequencer.sv
// Microprogram sequencer: next-address select, return stack, loop/address register.
// Every output is registered, so there is no combinational path from any input to uaddr.
module micro_sequencer #(
  parameter int ADDR_W = 11,
  parameter int STACK_DEPTH = 4,
  parameter int NCOND = 8,
  localparam int CSEL_W = $clog2(NCOND)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] d_in,
  input  logic [ADDR_W-1:0] or_in,
  input  logic [NCOND-1:0]  cond,
  input  logic [CSEL_W-1:0] cond_sel,
  input  logic              cond_pol,
  output logic [ADDR_W-1:0] uaddr,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_err
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH);

  typedef enum logic [3:0] {
    OP_CONT  = 4'd0,
    OP_JMP   = 4'd1,
    OP_JMPC  = 4'd2,
    OP_CALL  = 4'd3,
    OP_CALLC = 4'd4,
    OP_RET   = 4'd5,
    OP_RETC  = 4'd6,
    OP_LDAR  = 4'd7,
    OP_JAR   = 4'd8,
    OP_CASE  = 4'd9,
    OP_LOOP  = 4'd10,
    OP_CLR   = 4'd11
  } op_e;

  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [ADDR_W-1:0] ar, ar_n;
  logic [ADDR_W-1:0] upc, nxt, top;
  logic [SP_W-1:0]   sp, sp_n;
  logic              tcond, tsel;
  logic              do_push, do_pop, push_ok, err_set;

  assign upc = uaddr + 1'b1;

  always_comb begin
    tsel = 1'b0;
    for (int i = 0; i < NCOND; i++)
      if (CSEL_W'(i) == cond_sel) tsel = cond[i];
    tcond = tsel ^ cond_pol;
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (SP_W'(i + 1) == sp) top = stack[i];
  end

  always_comb begin
    nxt = upc;
    ar_n = ar;
    do_push = 1'b0;
    do_pop = 1'b0;
    sp_n = sp;
    err_set = 1'b0;
    push_ok = 1'b0;
    case (op_e'(op))
      OP_JMP:   nxt = d_in;
      OP_JMPC:  if (tcond) nxt = d_in;
      OP_CALL:  begin nxt = d_in; do_push = 1'b1; end
      OP_CALLC: if (tcond) begin nxt = d_in; do_push = 1'b1; end
      OP_RET:   do_pop = 1'b1;
      OP_RETC:  do_pop = tcond;
      OP_LDAR:  ar_n = d_in;
      OP_JAR:   nxt = ar;
      OP_CASE:  nxt = d_in | or_in;
      OP_LOOP:  if (ar != '0) begin ar_n = ar - 1'b1; nxt = d_in; end
      OP_CLR:   begin nxt = '0; sp_n = '0; end
      default:  nxt = upc;
    endcase
    if (do_push) begin
      if (sp == SP_MAX) err_set = 1'b1;
      else begin push_ok = 1'b1; sp_n = sp + 1'b1; end
    end
    // Underflowing return falls through to upc, already the default.
    if (do_pop) begin
      if (sp == '0) err_set = 1'b1;
      else begin nxt = top; sp_n = sp - 1'b1; end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uaddr <= '0;
      ar <= '0;
      sp <= '0;
      stack_err <= 1'b0;
      stack_empty <= 1'b1;
      stack_full <= 1'b0;
    end else if (!hold) begin
      uaddr <= nxt;
      ar <= ar_n;
      sp <= sp_n;
      stack_err <= stack_err | err_set;
      stack_empty <= (sp_n == '0);
      stack_full <= (sp_n == SP_MAX);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < STACK_DEPTH; i++)
      if (!hold && push_ok && SP_W'(i) == sp) stack[i] <= upc;
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with hand-computed expected addresses.
// NCOND=6 so that cond_sel values 6 and 7 exercise the out-of-range read.
module tb_micro_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [10:0] d_in = '0;
  logic [10:0] or_in = '0;
  logic [5:0]  cond = '0;
  logic [2:0]  cond_sel = '0;
  logic        cond_pol = 1'b0;
  logic [10:0] uaddr;
  logic        stack_empty, stack_full, stack_err;

  int checks = 0;
  int errors = 0;

  micro_sequencer #(.ADDR_W(11), .STACK_DEPTH(4), .NCOND(6)) dut (
    .clock(clock), .reset(reset), .hold(hold), .op(op),
    .d_in(d_in), .or_in(or_in), .cond(cond), .cond_sel(cond_sel),
    .cond_pol(cond_pol), .uaddr(uaddr), .stack_empty(stack_empty),
    .stack_full(stack_full), .stack_err(stack_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] o, input logic [10:0] d);
    op = o;
    d_in = d;
    @(posedge clock);
    #1;
  endtask

  initial begin
    @(posedge clock);
    #1;
    chk("rst_uaddr", 32'(uaddr), 32'h0);
    chk("rst_empty", 32'(stack_empty), 32'h1);
    chk("rst_full", 32'(stack_full), 32'h0);
    chk("rst_err", 32'(stack_err), 32'h0);
    reset = 1'b0;

    step(4'd0, 11'h0); chk("cont1", 32'(uaddr), 32'h1);
    step(4'd0, 11'h0); chk("cont2", 32'(uaddr), 32'h2);
    step(4'd0, 11'h0); chk("cont3", 32'(uaddr), 32'h3);
    chk("cont_empty", 32'(stack_empty), 32'h1);

    step(4'd1, 11'h7FF); chk("jmp_top", 32'(uaddr), 32'h7FF);
    step(4'd0, 11'h0); chk("wrap", 32'(uaddr), 32'h0);

    step(4'd1, 11'h010); chk("jmp10", 32'(uaddr), 32'h010);
    step(4'd3, 11'h200); chk("call", 32'(uaddr), 32'h200);
    chk("call_nempty", 32'(stack_empty), 32'h0);
    step(4'd5, 11'h0); chk("ret", 32'(uaddr), 32'h011);
    chk("ret_empty", 32'(stack_empty), 32'h1);
    chk("ret_err", 32'(stack_err), 32'h0);

    cond = 6'h04; cond_sel = 3'd2; cond_pol = 1'b0;
    step(4'd2, 11'h123); chk("jmpc_t", 32'(uaddr), 32'h123);
    cond_pol = 1'b1;
    step(4'd2, 11'h123); chk("jmpc_inv", 32'(uaddr), 32'h124);
    cond = 6'h3F; cond_sel = 3'd6; cond_pol = 1'b0;
    step(4'd2, 11'h300); chk("jmpc_oor0", 32'(uaddr), 32'h125);
    cond_pol = 1'b1;
    step(4'd2, 11'h300); chk("jmpc_oor1", 32'(uaddr), 32'h300);
    cond_pol = 1'b0;
    step(4'd6, 11'h0); chk("retc_nt", 32'(uaddr), 32'h301);
    chk("retc_nt_err", 32'(stack_err), 32'h0);
    step(4'd4, 11'h444); chk("callc_nt", 32'(uaddr), 32'h302);
    chk("callc_nt_empty", 32'(stack_empty), 32'h1);

    step(4'd7, 11'h002); chk("ldar", 32'(uaddr), 32'h303);
    step(4'd10, 11'h050); chk("loop1", 32'(uaddr), 32'h050);
    step(4'd10, 11'h050); chk("loop2", 32'(uaddr), 32'h050);
    step(4'd10, 11'h050); chk("loop3", 32'(uaddr), 32'h051);
    step(4'd8, 11'h0); chk("jar_zero", 32'(uaddr), 32'h000);
    step(4'd7, 11'h0AA); chk("ldar2", 32'(uaddr), 32'h001);
    step(4'd8, 11'h0); chk("jar", 32'(uaddr), 32'h0AA);

    hold = 1'b1;
    step(4'd1, 11'h777); chk("hold", 32'(uaddr), 32'h0AA);
    hold = 1'b0;
    or_in = 11'h003;
    step(4'd9, 11'h100); chk("case", 32'(uaddr), 32'h103);
    or_in = '0;

    step(4'd3, 11'h400); chk("c1", 32'(uaddr), 32'h400);
    step(4'd3, 11'h500); chk("c2", 32'(uaddr), 32'h500);
    step(4'd3, 11'h600); chk("c3", 32'(uaddr), 32'h600);
    chk("c3_full", 32'(stack_full), 32'h0);
    step(4'd3, 11'h700); chk("c4", 32'(uaddr), 32'h700);
    chk("c4_full", 32'(stack_full), 32'h1);
    chk("c4_err", 32'(stack_err), 32'h0);
    step(4'd3, 11'h080); chk("c5", 32'(uaddr), 32'h080);
    chk("c5_err", 32'(stack_err), 32'h1);
    chk("c5_full", 32'(stack_full), 32'h1);
    step(4'd5, 11'h0); chk("r1", 32'(uaddr), 32'h601);
    chk("r1_full", 32'(stack_full), 32'h0);
    step(4'd5, 11'h0); chk("r2", 32'(uaddr), 32'h501);
    step(4'd5, 11'h0); chk("r3", 32'(uaddr), 32'h401);
    step(4'd5, 11'h0); chk("r4", 32'(uaddr), 32'h104);
    chk("r4_empty", 32'(stack_empty), 32'h1);
    step(4'd5, 11'h0); chk("r5_fall", 32'(uaddr), 32'h105);
    chk("r5_err", 32'(stack_err), 32'h1);

    cond = 6'h04; cond_sel = 3'd2;
    step(4'd4, 11'h020); chk("callc_t", 32'(uaddr), 32'h020);
    chk("callc_nempty", 32'(stack_empty), 32'h0);
    step(4'd11, 11'h0); chk("clr", 32'(uaddr), 32'h000);
    chk("clr_empty", 32'(stack_empty), 32'h1);
    chk("clr_err", 32'(stack_err), 32'h1);
    step(4'd14, 11'h3FF); chk("rsvd", 32'(uaddr), 32'h001);
    step(4'd0, 11'h0); chk("pre_rst", 32'(uaddr), 32'h002);

    hold = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst", 32'(uaddr), 32'h0);
    chk("mid_rst_err", 32'(stack_err), 32'h0);
    #1 reset = 1'b0;
    hold = 1'b0;
    step(4'd0, 11'h0); chk("post_rst", 32'(uaddr), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter ADDR_W, default 11, microcode address width in bits (legal range 4..16).
REQ-002 Parameter STACK_DEPTH, default 4, number of return-stack entries (legal range 1..16).
REQ-003 Parameter NCOND, default 8, number of condition inputs (legal range 2..16); CSEL_W = clog2(NCOND).
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 hold  input  1  freezes all state when 1.
REQ-007 op  input  4  operation code, per REQ-014.
REQ-008 d_in  input  ADDR_W  branch target or address-register load value.
REQ-009 or_in  input  ADDR_W  case-branch OR mask.
REQ-010 cond  input  NCOND  condition vector.
REQ-011 cond_sel  input  CSEL_W  index of the tested condition; out-of-range index reads 0.
REQ-012 cond_pol  input  1  1 inverts the tested condition.
REQ-013 Outputs:
- uaddr  output  ADDR_W  registered current microcode address.
- stack_empty  output  1  registered; no entries on the stack.
- stack_full  output  1  registered; STACK_DEPTH entries on the stack.
- stack_err  output  1  sticky overflow/underflow flag.

Function
REQ-014 Opcodes (upc = uaddr+1 mod 2^ADDR_W; T = cond[cond_sel] XOR cond_pol; "next" means uaddr at the following edge):
- 0 CONT: next = upc.
- 1 JMP: next = d_in.
- 2 JMPC: next = T ? d_in : upc.
- 3 CALL: push upc; next = d_in.
- 4 CALLC: if T, CALL; else CONT.
- 5 RET: next = top of stack; pop.
- 6 RETC: if T, RET; else CONT.
- 7 LDAR: ar <= d_in; next = upc.
- 8 JAR: next = ar.
- 9 CASE: next = d_in | or_in.
- 10 LOOP: if ar != 0, then ar <= ar-1 and next = d_in; else next = upc.
- 11 CLR: next = 0; stack emptied; stack_err unchanged.
- 12-15 reserved; behave as CONT.
REQ-015 All state changes occur on the rising clock edge; uaddr is the single address output, with no combinational path from any input to uaddr.
REQ-016 Address arithmetic is modulo 2^ADDR_W: uaddr = 2^ADDR_W-1 with CONT gives 0.
REQ-017 Stack is LIFO, depth STACK_DEPTH, with a pointer sp counting 0..STACK_DEPTH; stack_empty = (sp==0) and stack_full = (sp==STACK_DEPTH).
REQ-018 Push with stack_full:
- the write is discarded and sp is unchanged;
- the jump still occurs;
- stack_err <= 1.
REQ-019 Pop with stack_empty:
- next = upc (fall through) and sp is unchanged;
- stack_err <= 1.
REQ-020 stack_err is cleared only by reset.
REQ-021 ar is an internal ADDR_W-bit address/loop register; LOOP with ar==0 leaves ar at 0.
REQ-022 hold=1 overrides op: uaddr, sp, stack contents, ar and flags are all unchanged.
REQ-023 A not-taken conditional (JMPC, CALLC, RETC) never modifies the stack or stack_err.

Reset
REQ-024 reset=1 asynchronously sets uaddr=0, sp=0, ar=0, stack_err=0, stack_empty=1 and stack_full=0; stack contents are don't-care.
REQ-025 Assertion of reset mid-operation, including during hold, takes effect immediately.
REQ-026 After deassertion, the first rising edge executes op normally from uaddr=0.

Verification
REQ-027 Reset, then CONT for 3 edges -> uaddr 0,1,2,3; stack_empty=1.
REQ-028 ADDR_W=11, at uaddr=0x7FF apply CONT -> uaddr=0x000.
REQ-029 At uaddr=0x010, CALL d_in=0x200, then RET -> uaddr 0x200, then 0x011; stack_empty returns to 1; stack_err=0.
REQ-030 STACK_DEPTH=4: 5 consecutive CALLs -> stack_full after the 4th, stack_err=1 after the 5th; then 5 RETs -> the first 4 return in LIFO order, the 5th falls through to upc.
REQ-031 Conditions:
- cond=0x04, cond_sel=2, cond_pol=0, JMPC d_in=0x123 -> uaddr=0x123.
- Same stimulus with cond_pol=1 -> uaddr=upc.
- cond_sel out of range -> tested condition reads 0.
REQ-032 Loop, hold, case and mid-operation reset:
- LDAR d_in=2, then LOOP d_in=0x050 three times -> 0x050, 0x050, then upc.
- hold=1 during JMP -> no change.
- CASE d_in=0x100, or_in=0x003 -> uaddr=0x103.
- Reset asserted between edges -> uaddr=0 immediately.
